// File: rtl/rate_monitor.sv
// Sliding-window rate averager with running min/max and a persistence-filtered
// HIGH/LOW alarm FSM on the averaged rate. Three-edge pipeline, no stalls.
`timescale 1ns/1ps
module rate_monitor #(
  parameter int AVG_LOG2   = 3,
  parameter int HI_PERSIST = 2,
  parameter int LO_PERSIST = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_rate,
  input  logic        clear,
  input  logic [31:0] hi_thresh,
  input  logic [31:0] lo_thresh,
  output logic        avg_valid,
  output logic [31:0] avg_rate,
  output logic [31:0] min_rate,
  output logic [31:0] max_rate,
  output logic        primed,
  output logic        alarm_hi,
  output logic        alarm_lo
);

  localparam int DEPTH  = 1 << AVG_LOG2;
  localparam int SUM_W  = 32 + AVG_LOG2;
  localparam int FILL_W = AVG_LOG2 + 1;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);
  localparam logic [4:0]        HI_LIM    = 5'(HI_PERSIST);
  localparam logic [4:0]        LO_LIM    = 5'(LO_PERSIST);

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_HIGH   = 2'd1,
    ST_LOW    = 2'd2
  } state_t;

  logic [31:0]         r_buf [DEPTH];
  logic [AVG_LOG2-1:0] r_wptr;
  logic [FILL_W-1:0]   r_fill;
  logic [SUM_W-1:0]    r_sum;
  logic                r_s1_valid;
  logic                r_primed;
  logic [31:0]         r_min;
  logic [31:0]         r_max;
  logic                r_avg_valid;
  logic [31:0]         r_avg_rate;
  state_t              r_state;
  logic [3:0]          r_hc;
  logic [3:0]          r_lc;
  logic                r_alarm_hi;
  logic                r_alarm_lo;

  logic                w_accept;
  logic                w_full;
  logic [31:0]         w_oldest;
  logic [FILL_W-1:0]   w_fill_nxt;
  logic                w_full_nxt;
  logic [SUM_W-1:0]    w_sum_nxt;
  logic                w_above;
  logic                w_below;
  logic [4:0]          w_hc_inc;
  logic [4:0]          w_lc_inc;
  logic [4:0]          w_hc_c;
  logic [4:0]          w_lc_c;
  state_t              w_state_nxt;
  logic [3:0]          w_hc_nxt;
  logic [3:0]          w_lc_nxt;

  // Until the window has filled, the slot being overwritten holds stale data and counts as zero.
  assign w_accept   = in_valid & ~clear;
  assign w_full     = (r_fill == FILL_FULL);
  assign w_oldest   = w_full ? r_buf[r_wptr] : 32'd0;
  assign w_fill_nxt = w_full ? r_fill : (r_fill + FILL_W'(1));
  assign w_full_nxt = (w_fill_nxt == FILL_FULL);
  assign w_sum_nxt  = r_sum + SUM_W'(in_rate) - SUM_W'(w_oldest);

  assign w_above  = (r_avg_rate > hi_thresh);
  assign w_below  = (r_avg_rate < lo_thresh);
  assign w_hc_inc = {1'b0, r_hc} + 5'd1;
  assign w_lc_inc = {1'b0, r_lc} + 5'd1;

  // Sample storage; deliberately unreset, history validity is tracked by r_fill.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf[r_wptr] <= in_rate;
    end
  end

  // Stage 1: window sum, write pointer, fill level, min/max.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum      <= {SUM_W{1'b0}};
      r_wptr     <= {AVG_LOG2{1'b0}};
      r_fill     <= {FILL_W{1'b0}};
      r_primed   <= 1'b0;
      r_s1_valid <= 1'b0;
      r_min      <= 32'hFFFF_FFFF;
      r_max      <= 32'd0;
    end else if (clear) begin
      r_sum      <= {SUM_W{1'b0}};
      r_wptr     <= {AVG_LOG2{1'b0}};
      r_fill     <= {FILL_W{1'b0}};
      r_primed   <= 1'b0;
      r_s1_valid <= 1'b0;
      r_min      <= 32'hFFFF_FFFF;
      r_max      <= 32'd0;
    end else if (w_accept) begin
      r_sum      <= w_sum_nxt;
      r_wptr     <= r_wptr + AVG_LOG2'(1);
      r_fill     <= w_fill_nxt;
      r_primed   <= w_full_nxt;
      r_s1_valid <= w_full_nxt;
      r_min      <= (in_rate < r_min) ? in_rate : r_min;
      r_max      <= (in_rate > r_max) ? in_rate : r_max;
    end else begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage 2: publish the truncated average of the sum formed on the previous edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_avg_valid <= 1'b0;
      r_avg_rate  <= 32'd0;
    end else if (clear) begin
      r_avg_valid <= 1'b0;
      r_avg_rate  <= 32'd0;
    end else begin
      r_avg_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_avg_rate <= r_sum[SUM_W-1:AVG_LOG2];
      end
    end
  end

  // Stage 3 next-state: in HIGH a run of low averages wins over the exit run; elsewhere high wins.
  always_comb begin
    w_state_nxt = r_state;
    w_hc_nxt    = r_hc;
    w_lc_nxt    = r_lc;
    w_hc_c      = 5'd0;
    w_lc_c      = 5'd0;
    if (r_avg_valid) begin
      case (r_state)
        ST_NORMAL: begin
          w_hc_c = w_above ? w_hc_inc : 5'd0;
          w_lc_c = (!w_above && w_below) ? w_lc_inc : 5'd0;
          if (w_hc_c >= HI_LIM) begin
            w_state_nxt = ST_HIGH;
          end else if (w_lc_c >= LO_LIM) begin
            w_state_nxt = ST_LOW;
          end else begin
            w_state_nxt = ST_NORMAL;
          end
        end
        ST_HIGH: begin
          w_hc_c = w_above ? 5'd0 : w_hc_inc;
          w_lc_c = w_below ? w_lc_inc : 5'd0;
          if (w_lc_c >= LO_LIM) begin
            w_state_nxt = ST_LOW;
          end else if (w_hc_c >= HI_LIM) begin
            w_state_nxt = ST_NORMAL;
          end else begin
            w_state_nxt = ST_HIGH;
          end
        end
        ST_LOW: begin
          w_hc_c = w_above ? w_hc_inc : 5'd0;
          w_lc_c = w_below ? 5'd0 : w_lc_inc;
          if (w_hc_c >= HI_LIM) begin
            w_state_nxt = ST_HIGH;
          end else if (w_lc_c >= LO_LIM) begin
            w_state_nxt = ST_NORMAL;
          end else begin
            w_state_nxt = ST_LOW;
          end
        end
        default: begin
          w_state_nxt = ST_NORMAL;
        end
      endcase
      if (w_state_nxt != r_state) begin
        w_hc_nxt = 4'd0;
        w_lc_nxt = 4'd0;
      end else begin
        w_hc_nxt = w_hc_c[3:0];
        w_lc_nxt = w_lc_c[3:0];
      end
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Stage 3 state register with alarms decoded from the next state so they move with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_NORMAL;
      r_hc       <= 4'd0;
      r_lc       <= 4'd0;
      r_alarm_hi <= 1'b0;
      r_alarm_lo <= 1'b0;
    end else if (clear) begin
      r_state    <= ST_NORMAL;
      r_hc       <= 4'd0;
      r_lc       <= 4'd0;
      r_alarm_hi <= 1'b0;
      r_alarm_lo <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hc       <= w_hc_nxt;
      r_lc       <= w_lc_nxt;
      r_alarm_hi <= (w_state_nxt == ST_HIGH);
      r_alarm_lo <= (w_state_nxt == ST_LOW);
    end
  end

  assign avg_valid = r_avg_valid;
  assign avg_rate  = r_avg_rate;
  assign min_rate  = r_min;
  assign max_rate  = r_max;
  assign primed    = r_primed;
  assign alarm_hi  = r_alarm_hi;
  assign alarm_lo  = r_alarm_lo;

endmodule

// File: tb/tb_rate_monitor.sv
// Self-checking bench for rate_monitor: directed scenarios plus randomized traffic,
// all compared every cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_rate_monitor;

  localparam int AVG_LOG2 = 3;
  localparam int HI_P     = 2;
  localparam int LO_P     = 2;
  localparam int DEPTH    = 1 << AVG_LOG2;
  localparam int M_NORMAL = 0;
  localparam int M_HIGH   = 1;
  localparam int M_LOW    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_rate;
  logic        clear;
  logic [31:0] hi_thresh;
  logic [31:0] lo_thresh;
  logic        avg_valid;
  logic [31:0] avg_rate;
  logic [31:0] min_rate;
  logic [31:0] max_rate;
  logic        primed;
  logic        alarm_hi;
  logic        alarm_lo;

  always #5 clk = ~clk;

  rate_monitor #(.AVG_LOG2(AVG_LOG2), .HI_PERSIST(HI_P), .LO_PERSIST(LO_P)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_rate(in_rate), .clear(clear),
    .hi_thresh(hi_thresh), .lo_thresh(lo_thresh), .avg_valid(avg_valid),
    .avg_rate(avg_rate), .min_rate(min_rate), .max_rate(max_rate), .primed(primed),
    .alarm_hi(alarm_hi), .alarm_lo(alarm_lo)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: window as a queue of the most recent samples.
  logic [31:0] m_win[$];
  logic [31:0] m_min, m_max, m_avg_rate, m_p2_val;
  bit          m_avg_valid, m_p2;
  int          m_state, m_hc, m_lc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0d (0x%08h), expected %0d (0x%08h) at t=%0t",
                  tag, obs, obs, exp, exp, $time);
  endtask

  task automatic model_reset();
    m_win.delete();
    m_min = 32'hFFFF_FFFF; m_max = 32'd0;
    m_avg_rate = 32'd0; m_avg_valid = 1'b0;
    m_p2 = 1'b0; m_p2_val = 32'd0;
    m_state = M_NORMAL; m_hc = 0; m_lc = 0;
  endtask

  task automatic model_fsm(input logic [31:0] a);
    bit above = (a > hi_thresh);
    bit below = (a < lo_thresh);
    int hi_run, lo_run, nxt;
    nxt = m_state;
    case (m_state)
      M_NORMAL: begin
        hi_run = above ? m_hc + 1 : 0;
        lo_run = (!above && below) ? m_lc + 1 : 0;
        if (hi_run >= HI_P) nxt = M_HIGH;
        else if (lo_run >= LO_P) nxt = M_LOW;
      end
      M_HIGH: begin
        hi_run = above ? 0 : m_hc + 1;
        lo_run = below ? m_lc + 1 : 0;
        if (lo_run >= LO_P) nxt = M_LOW;
        else if (hi_run >= HI_P) nxt = M_NORMAL;
      end
      default: begin
        hi_run = above ? m_hc + 1 : 0;
        lo_run = below ? 0 : m_lc + 1;
        if (hi_run >= HI_P) nxt = M_HIGH;
        else if (lo_run >= LO_P) nxt = M_NORMAL;
      end
    endcase
    if (nxt != m_state) begin m_hc = 0; m_lc = 0; end
    else begin m_hc = hi_run; m_lc = lo_run; end
    m_state = nxt;
  endtask

  // One clock edge of the model; older pipeline stages are advanced first.
  task automatic model_edge(input bit v, input logic [31:0] r, input bit c);
    longint unsigned s;
    if (c) begin
      model_reset();
      return;
    end
    if (m_avg_valid) model_fsm(m_avg_rate);
    m_avg_valid = m_p2;
    if (m_p2) m_avg_rate = m_p2_val;
    m_p2 = 1'b0;
    if (v) begin
      m_win.push_back(r);
      if (m_win.size() > DEPTH) void'(m_win.pop_front());
      if (r < m_min) m_min = r;
      if (r > m_max) m_max = r;
      if (m_win.size() == DEPTH) begin
        s = 0;
        foreach (m_win[i]) s += m_win[i];
        m_p2 = 1'b1;
        m_p2_val = 32'(s / DEPTH);
      end
    end
  endtask

  task automatic check_all();
    check("avg_valid", avg_valid, m_avg_valid);
    check("avg_rate", avg_rate, m_avg_rate);
    check("min_rate", min_rate, m_min);
    check("max_rate", max_rate, m_max);
    check("primed", primed, (m_win.size() == DEPTH));
    check("alarm_hi", alarm_hi, (m_state == M_HIGH));
    check("alarm_lo", alarm_lo, (m_state == M_LOW));
  endtask

  // Drive one cycle's inputs at the falling edge, step the model, check at the next falling edge.
  task automatic tick(input bit v, input logic [31:0] r, input bit c);
    in_valid = v; in_rate = r; clear = c;
    @(posedge clk);
    model_edge(v, r, c);
    @(negedge clk);
    check_all();
    in_valid = 1'b0; in_rate = 32'd0; clear = 1'b0;
  endtask

  // One sample, then enough idle edges for its average to reach the alarm FSM.
  task automatic feed(input logic [31:0] r);
    tick(1'b1, r, 1'b0);
    tick(1'b0, 32'd0, 1'b0);
    tick(1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0; in_valid = 1'b0; in_rate = 32'd0; clear = 1'b0;
    hi_thresh = 32'hFFFF_FFFF; lo_thresh = 32'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    check("reset_min", min_rate, 32'hFFFF_FFFF);
    rst_n = 1'b1;

    // Priming with a constant rate, one spike, then recovery.
    for (int i = 0; i < DEPTH; i++) begin
      tick(1'b1, 32'd100, 1'b0);
      if (i < DEPTH - 1) repeat (4) tick(1'b0, 32'd0, 1'b0);
    end
    check("first_avg_not_yet", avg_valid, 1'b0);
    tick(1'b0, 32'd0, 1'b0);
    check("first_avg_valid", avg_valid, 1'b1);
    check("first_avg_rate", avg_rate, 32'd100);
    check("first_primed", primed, 1'b1);
    check("first_min", min_rate, 32'd100);
    check("first_max", max_rate, 32'd100);
    feed(32'd900);
    check("spike_avg", avg_rate, 32'd200);
    check("spike_max", max_rate, 32'd900);
    repeat (DEPTH) feed(32'd100);
    check("recover_avg", avg_rate, 32'd100);

    // HIGH entry with persistence, interrupted exit, then exit to NORMAL.
    hi_thresh = 32'd150; lo_thresh = 32'd50;
    tick(1'b0, 32'd0, 1'b1);
    repeat (DEPTH) feed(32'd200);
    check("hi_after_1st", alarm_hi, 1'b0);
    tick(1'b1, 32'd200, 1'b0);
    tick(1'b0, 32'd0, 1'b0);
    check("hi_latency_2", alarm_hi, 1'b0);
    tick(1'b0, 32'd0, 1'b0);
    check("hi_latency_3", alarm_hi, 1'b1);
    feed(32'd0);
    feed(32'd0);
    feed(32'd1000);
    check("hi_exit_reset", alarm_hi, 1'b1);
    repeat (4) feed(32'd0);
    check("hi_hold", alarm_hi, 1'b1);
    feed(32'd0);
    check("hi_exit", alarm_hi, 1'b0);

    // Direct HIGH to LOW.
    tick(1'b0, 32'd0, 1'b1);
    repeat (DEPTH + 1) feed(32'd200);
    check("hl_in_high", alarm_hi, 1'b1);
    feed(32'd1400);
    repeat (DEPTH) feed(32'd0);
    check("hl_still_high", alarm_hi, 1'b1);
    feed(32'd0);
    check("hl_hi_off", alarm_hi, 1'b0);
    check("hl_lo_on", alarm_lo, 1'b1);

    // Back-to-back samples 1..16.
    hi_thresh = 32'd5; lo_thresh = 32'd0;
    tick(1'b0, 32'd0, 1'b1);
    pulses = 0;
    for (int i = 1; i <= 16; i++) begin
      tick(1'b1, 32'(i), 1'b0);
      if (avg_valid) pulses++;
    end
    repeat (2) begin
      tick(1'b0, 32'd0, 1'b0);
      if (avg_valid) pulses++;
    end
    check("b2b_pulses", 32'(pulses), 32'd9);
    check("b2b_avg", avg_rate, 32'd12);
    check("b2b_min", min_rate, 32'd1);
    check("b2b_max", max_rate, 32'd16);
    check("b2b_high", alarm_hi, 1'b1);

    // Clear wins over a coincident sample.
    tick(1'b1, 32'd5000, 1'b1);
    check("clr_max", max_rate, 32'd0);
    check("clr_min", min_rate, 32'hFFFF_FFFF);
    check("clr_alarm", alarm_hi, 1'b0);
    repeat (3) tick(1'b0, 32'd0, 1'b0);
    check("clr_no_avg", avg_valid, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      bit v, c;
      logic [31:0] r;
      if (i % 150 == 0) begin
        hi_thresh = $urandom_range(80, 260);
        lo_thresh = $urandom_range(0, 120);
      end
      v = ($urandom_range(0, 2) != 0);
      c = ($urandom_range(0, 199) == 0);
      r = ($urandom_range(0, 19) == 0) ? 32'($urandom) : 32'($urandom_range(0, 320));
      tick(v, r, c);
    end

    // Asynchronous reset with a sample in flight.
    hi_thresh = 32'd150; lo_thresh = 32'd50;
    tick(1'b0, 32'd0, 1'b1);
    repeat (12) tick(1'b1, 32'd200, 1'b0);
    check("ar_pre_high", alarm_hi, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check("ar_primed", primed, 1'b0);
    check("ar_alarm", alarm_hi, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
    pulses = 0;
    repeat (4) begin
      tick(1'b0, 32'd0, 1'b0);
      if (avg_valid) pulses++;
    end
    check("ar_no_avg", 32'(pulses), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
